// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage: result-source
// encodings, condition-code constants and the register/word typedefs.
package writeback_pkg;

  localparam int WORD_W  = 16;
  localparam int REG_NUM = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [2:0]        reg_addr_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_NPC = 2'd3
  } wb_sel_e;

  localparam logic [2:0] PSR_N = 3'b100;
  localparam logic [2:0] PSR_Z = 3'b010;
  localparam logic [2:0] PSR_P = 3'b001;

  // Condition codes of a committed word: sign bit first, then zero, else positive.
  function automatic logic [2:0] cond_codes(input word_t value);
    if (value[WORD_W-1])
      return PSR_N;
    else if (value == '0)
      return PSR_Z;
    else
      return PSR_P;
  endfunction

endpackage

// File: rtl/writeback_regfile.sv
// 8 x 16-bit register file: one synchronous write port, two combinational
// read ports, synchronous active-low clear of every entry. No register is
// hardwired, so R0 and R7 behave like the others.
module writeback_regfile
  import writeback_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      we,
  input  reg_addr_t waddr,
  input  word_t     wdata,
  input  reg_addr_t raddr1,
  input  reg_addr_t raddr2,
  output word_t     rdata1,
  output word_t     rdata2
);

  word_t regs_q [REG_NUM];
  word_t regs_d [REG_NUM];

  // Next-state of the array: only the addressed entry changes on a write.
  always_comb begin
    regs_d = regs_q;
    if (we)
      regs_d[waddr] = wdata;
  end

  // Register array update; reset clears everything and discards the write.
  always_ff @(posedge clock) begin
    if (!reset)
      regs_q <= '{default: '0};
    else
      regs_q <= regs_d;
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/writeback.sv
// Writeback stage: selects the result to commit, writes it into the
// register file and updates the {N,Z,P} condition codes in psr.
// Optional macro WRITEBACK_BYPASS_EN makes the read ports write-through
// for a register being written in the same cycle.
module writeback
  import writeback_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_writeback,
  input  logic [1:0]  W_control_in,
  input  logic [15:0] aluout,
  input  logic [15:0] memout,
  input  logic [15:0] pcout,
  input  logic [15:0] npc,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  input  logic [2:0]  dr,
  output logic [15:0] VSR1,
  output logic [15:0] VSR2,
  output logic [2:0]  psr
);

  word_t      dr_in;
  word_t      rf_rd1;
  word_t      rf_rd2;
  logic [2:0] psr_d;
  logic [2:0] psr_q;

  // Result-source mux feeding the register-file write port.
  always_comb begin
    dr_in = aluout;
    case (wb_sel_e'(W_control_in))
      WB_ALU:  dr_in = aluout;
      WB_MEM:  dr_in = memout;
      WB_PC:   dr_in = pcout;
      default: dr_in = npc;
    endcase
  end

  writeback_regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (enable_writeback),
    .waddr  (dr),
    .wdata  (dr_in),
    .raddr1 (sr1),
    .raddr2 (sr2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // Condition codes follow every committed write and hold otherwise.
  always_comb begin
    psr_d = psr_q;
    if (enable_writeback)
      psr_d = cond_codes(dr_in);
  end

  // psr register; clears to 3'b000 (not a valid code) until the first write.
  always_ff @(posedge clock) begin
    if (!reset)
      psr_q <= 3'b000;
    else
      psr_q <= psr_d;
  end

  assign psr = psr_q;

`ifdef WRITEBACK_BYPASS_EN
  // Write-through read ports; a reset in progress blocks the forward.
  always_comb begin
    VSR1 = rf_rd1;
    VSR2 = rf_rd2;
    if (reset && enable_writeback && (sr1 == dr))
      VSR1 = dr_in;
    if (reset && enable_writeback && (sr2 == dr))
      VSR2 = dr_in;
  end
`else
  // Plain read ports: a write becomes visible only after its edge.
  always_comb begin
    VSR1 = rf_rd1;
    VSR2 = rf_rd2;
  end
`endif

endmodule
